alu_flags_register: RTL and testbench
=====================================

Name: alu_flags_register

Overview:
- Holds the processor status flags ZF, SF, CF, OF and PF, updated from the ALU result plus the ALU's carry and overflow outputs.
- Sits between the ALU and the control unit/branch logic.
- Also provides a packed flag word for save/restore, as needed by PUSHF/POPF-style operations.

Parameters:
- DATA_W, 8, width of alu_result in bits; must be at least 8.

Ports:
- clk  input  1  system clock; all updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_result  input  DATA_W  ALU result for the current operation.
- carry_in  input  1  carry/borrow produced by the ALU.
- overflow_in  input  1  signed overflow produced by the ALU.
- update_flags  input  1  when high, capture all flags from the ALU inputs at the next rising edge.
- flags_load  input  1  when high, load all flags from flags_in at the next rising edge.
- flags_in  input  5  packed flag word: [0]=CF, [1]=PF, [2]=ZF, [3]=SF, [4]=OF.
- zero_flag  output  1  ZF.
- sign_flag  output  1  SF.
- carry_flag  output  1  CF.
- overflow_flag  output  1  OF.
- parity_flag  output  1  PF.
- flags_out  output  5  packed copy of the current flags, same bit order as flags_in.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: while rst is high, all five flags are 0 and flags_out=5'b00000, regardless of clock. Reset asserted mid-operation clears immediately and overrides any pending update.
- On each rising edge with rst low, priority is rst > flags_load > update_flags > hold.
- flags_load=1 (wins over update_flags if both are high): CF<=flags_in[0], PF<=flags_in[1], ZF<=flags_in[2], SF<=flags_in[3], OF<=flags_in[4].
- update_flags=1: all five flags are written together.
  - ZF <= (alu_result == 0), all DATA_W bits compared.
  - SF <= alu_result[DATA_W-1].
  - CF <= carry_in.
  - OF <= overflow_in.
  - PF <= even parity (XNOR-reduce) of alu_result[7:0], i.e. 1 when the low byte has an even number of ones, per 8086 convention, independent of DATA_W.
- Neither flags_load nor update_flags: all flags hold.
- Latency: one cycle. A flag changes on the rising edge where the enable is sampled high and is visible immediately after that edge.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- flags_out is wired directly from the flag registers, so it always equals the individual outputs.
- No partial-flag updates: every write affects all five flags.
- Sample inputs are don't-care when their enable is low; X on them must not propagate.

Decomposition:
- Shared package holds:
  - Flag bit index constants (FLAG_CF=0, FLAG_PF=1, FLAG_ZF=2, FLAG_SF=3, FLAG_OF=4).
  - FLAGS_W=5.
  - A packed struct typedef for the flag word, so the ALU and control unit use the same layout.
- One natural combinational sub-module, alu_flag_gen, computes next ZF/SF/PF from alu_result. The ALU may reuse it. The register itself stays in this block.

Test Plan:
- Reset: rst=1 for 10 ns with random inputs -> all flags 0, flags_out=00000. Asserting rst asynchronously between clock edges mid-run clears the flags immediately.
- Zero result: alu_result=8'h00, carry_in=0, overflow_in=0, update_flags=1, one edge -> ZF=1, SF=0, CF=0, OF=0, PF=1, flags_out=5'b00110.
- Sign result: alu_result=8'h80, update_flags=1 -> ZF=0, SF=1, PF=0, CF=0, OF=0.
- All ones with carry/overflow: alu_result=8'hFF, carry_in=1, overflow_in=1, update_flags=1 -> ZF=0, SF=1, CF=1, OF=1, PF=1, flags_out=5'b11011.
- Hold: after the previous case, update_flags=0, alu_result=8'h00, carry_in=0 for 3 edges -> flags unchanged at 5'b11011. Odd parity check: alu_result=8'h07, update_flags=1 -> PF=0.
- Load priority: flags_load=1 with flags_in=5'b10101, update_flags=1 and alu_result=8'h00, same edge -> OF=1, SF=0, ZF=1, PF=0, CF=1 (load wins). Next edge with flags_load=0, update_flags=1 -> ALU-derived values take effect.

Source files
------------

// File: rtl/alu_flags_register_pkg.sv
// alu_flags_register_pkg: shared flag-word layout for the ALU, flag register and control unit.
// Revision: 1.0
`default_nettype none

package alu_flags_register_pkg;

   localparam int FLAGS_W = 5;

   localparam int FLAG_CF = 0;
   localparam int FLAG_PF = 1;
   localparam int FLAG_ZF = 2;
   localparam int FLAG_SF = 3;
   localparam int FLAG_OF = 4;

   // Declared MSB first so the packed bit positions match the FLAG_* indices.
   typedef struct packed {
      logic of_f;
      logic sf_f;
      logic zf_f;
      logic pf_f;
      logic cf_f;
   } flags_t;

   function automatic logic even_parity8(input logic [7:0] value);
      return ~^value;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational ZF/SF/PF derivation from an ALU result.
// Revision: 1.0
`default_nettype none

module alu_flag_gen
   import alu_flags_register_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] alu_result,
   output logic              zero_next,
   output logic              sign_next,
   output logic              parity_next
);

   // Parity follows the 8086 convention: low byte only, whatever DATA_W is.
   assign zero_next   = (alu_result == '0);
   assign sign_next   = alu_result[DATA_W-1];
   assign parity_next = even_parity8(alu_result[7:0]);

endmodule

`default_nettype wire

// File: rtl/alu_flags_register.sv
// alu_flags_register: ZF/SF/CF/OF/PF status register with ALU update and packed load.
// Revision: 1.0
`default_nettype none

module alu_flags_register
   import alu_flags_register_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               carry_in,
   input  logic               overflow_in,
   input  logic               update_flags,
   input  logic               flags_load,
   input  logic [FLAGS_W-1:0] flags_in,
   output logic               zero_flag,
   output logic               sign_flag,
   output logic               carry_flag,
   output logic               overflow_flag,
   output logic               parity_flag,
   output logic [FLAGS_W-1:0] flags_out
);

   flags_t r_flags;
   flags_t w_alu_flags;
   logic   w_zero_next;
   logic   w_sign_next;
   logic   w_parity_next;

   alu_flag_gen #(
      .DATA_W (DATA_W)
   ) u_flag_gen (
      .alu_result  (alu_result),
      .zero_next   (w_zero_next),
      .sign_next   (w_sign_next),
      .parity_next (w_parity_next)
   );

   always_comb begin
      w_alu_flags      = '0;
      w_alu_flags.cf_f = carry_in;
      w_alu_flags.pf_f = w_parity_next;
      w_alu_flags.zf_f = w_zero_next;
      w_alu_flags.sf_f = w_sign_next;
      w_alu_flags.of_f = overflow_in;
   end

   // Load outranks ALU update; every write replaces all five flags together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= '0;
      end else if (flags_load) begin
         r_flags <= flags_t'(flags_in);
      end else if (update_flags) begin
         r_flags <= w_alu_flags;
      end
   end

   assign flags_out     = r_flags;
   assign carry_flag    = flags_out[FLAG_CF];
   assign parity_flag   = flags_out[FLAG_PF];
   assign zero_flag     = flags_out[FLAG_ZF];
   assign sign_flag     = flags_out[FLAG_SF];
   assign overflow_flag = flags_out[FLAG_OF];

endmodule

`default_nettype wire

// File: tb/tb_alu_flags_register.sv
// tb_alu_flags_register: directed self-checking bench for alu_flags_register.
// Revision: 1.0
`default_nettype none

module tb_alu_flags_register;

   logic       clk;
   logic       rst;
   logic [7:0] alu_result;
   logic       carry_in;
   logic       overflow_in;
   logic       update_flags;
   logic       flags_load;
   logic [4:0] flags_in;
   logic       zero_flag;
   logic       sign_flag;
   logic       carry_flag;
   logic       overflow_flag;
   logic       parity_flag;
   logic [4:0] flags_out;

   int tests_run;
   int tests_failed;

   alu_flags_register #(
      .DATA_W (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_result    (alu_result),
      .carry_in      (carry_in),
      .overflow_in   (overflow_in),
      .update_flags  (update_flags),
      .flags_load    (flags_load),
      .flags_in      (flags_in),
      .zero_flag     (zero_flag),
      .sign_flag     (sign_flag),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .parity_flag   (parity_flag),
      .flags_out     (flags_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs on the falling edge, then settle just past the next rising edge.
   task automatic apply(input logic [7:0] res, input logic c, input logic o,
                        input logic upd, input logic ld, input logic [4:0] fin);
      @(negedge clk);
      alu_result   = res;
      carry_in     = c;
      overflow_in  = o;
      update_flags = upd;
      flags_load   = ld;
      flags_in     = fin;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_result   = 8'($urandom);
         carry_in     = 1'($urandom);
         overflow_in  = 1'($urandom);
         update_flags = 1'($urandom);
         flags_load   = 1'($urandom);
         flags_in     = 5'($urandom);
         #2.5;
      end
      tests_run++;
      if (flags_out !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_flags_out: got %b expected %b", flags_out, 5'b00000);
      end
      tests_run++;
      if ({overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_individual: got %b expected %b",
                  {overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag}, 5'b00000);
      end
      @(negedge clk);
      update_flags = 1'b0;
      flags_load   = 1'b0;
      rst          = 1'b0;
   endtask

   task automatic test_zero_result();
      apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if (flags_out !== 5'b00110) begin
         tests_failed++;
         $display("FAIL zero_flags_out: got %b expected %b", flags_out, 5'b00110);
      end
      tests_run++;
      if ({overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag} !== 5'b00110) begin
         tests_failed++;
         $display("FAIL zero_individual: got %b expected %b",
                  {overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag}, 5'b00110);
      end
   endtask

   task automatic test_sign_result();
      apply(8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if ({overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag} !== 5'b01000) begin
         tests_failed++;
         $display("FAIL sign_individual: got %b expected %b",
                  {overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag}, 5'b01000);
      end
   endtask

   task automatic test_all_ones();
      apply(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if (flags_out !== 5'b11011) begin
         tests_failed++;
         $display("FAIL all_ones_flags_out: got %b expected %b", flags_out, 5'b11011);
      end
      tests_run++;
      if ({overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag} !== 5'b11011) begin
         tests_failed++;
         $display("FAIL all_ones_individual: got %b expected %b",
                  {overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag}, 5'b11011);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) begin
         apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
         tests_run++;
         if (flags_out !== 5'b11011) begin
            tests_failed++;
            $display("FAIL hold_edge%0d: got %b expected %b", i, flags_out, 5'b11011);
         end
      end
      // X on sample inputs must not leak while both enables are low.
      apply(8'hxx, 1'bx, 1'bx, 1'b0, 1'b0, 5'bxxxxx);
      tests_run++;
      if (flags_out !== 5'b11011) begin
         tests_failed++;
         $display("FAIL hold_x_inputs: got %b expected %b", flags_out, 5'b11011);
      end
   endtask

   task automatic test_odd_parity();
      apply(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if (flags_out !== 5'b00001) begin
         tests_failed++;
         $display("FAIL odd_parity_07: got %b expected %b", flags_out, 5'b00001);
      end
      apply(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if (flags_out !== 5'b10010) begin
         tests_failed++;
         $display("FAIL even_parity_3c: got %b expected %b", flags_out, 5'b10010);
      end
   endtask

   task automatic test_load_priority();
      apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10101);
      tests_run++;
      if ({overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag} !== 5'b10101) begin
         tests_failed++;
         $display("FAIL load_priority: got %b expected %b",
                  {overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag}, 5'b10101);
      end
      apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10101);
      tests_run++;
      if (flags_out !== 5'b00110) begin
         tests_failed++;
         $display("FAIL update_after_load: got %b expected %b", flags_out, 5'b00110);
      end
      apply(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 5'b01010);
      tests_run++;
      if (flags_out !== 5'b01010) begin
         tests_failed++;
         $display("FAIL load_only: got %b expected %b", flags_out, 5'b01010);
      end
   endtask

   task automatic test_async_reset();
      apply(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if (flags_out !== 5'b11011) begin
         tests_failed++;
         $display("FAIL async_setup: got %b expected %b", flags_out, 5'b11011);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (flags_out !== 5'b00000) begin
         tests_failed++;
         $display("FAIL async_reset_immediate: got %b expected %b", flags_out, 5'b00000);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (flags_out !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_over_update: got %b expected %b", flags_out, 5'b00000);
      end
      @(negedge clk);
      rst = 1'b0;
      apply(8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000);
      tests_run++;
      if (flags_out !== 5'b01001) begin
         tests_failed++;
         $display("FAIL update_after_reset: got %b expected %b", flags_out, 5'b01001);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      alu_result   = 8'h00;
      carry_in     = 1'b0;
      overflow_in  = 1'b0;
      update_flags = 1'b0;
      flags_load   = 1'b0;
      flags_in     = 5'b00000;

      test_reset();
      test_zero_result();
      test_sign_result();
      test_all_ones();
      test_hold();
      test_odd_parity();
      test_load_priority();
      test_async_reset();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
